// File: rtl/if_fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage: opcodes, bubble word, FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package if_fetch_stage_pkg;

   localparam logic [6:0]  OP_UNCONDITIONAL_JMP = 7'b1101111;
   localparam logic [31:0] NOP_INSTR            = 32'h00000013;

   // Fetch FSM encoding (kept as plain constants for legacy tool compatibility)
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   // One IF/ID slot: instruction word, its PC, and the predicted-taken flag
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        take;
   } ifid_t;

endpackage

// File: rtl/if_next_pc.sv
// Next fetch address: pc+4, or pc+J-immediate for a JAL when IF_STATIC_JAL_EN is defined.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is committed.
module if_next_pc
   import if_fetch_stage_pkg::*;
(
   input  logic [31:0]  pc,
`ifdef IF_STATIC_JAL_EN
   input  logic [6:0]   opcode,
   input  logic [31:12] jimm_bits,
`endif
   output logic [31:0]  next_pc,
   output logic         take
);

`ifdef IF_STATIC_JAL_EN
   logic        is_jal;
   logic [31:0] jimm;

   // J-type immediate: imm[20|10:1|11|19:12] live in word bits [31|30:21|20|19:12]
   assign is_jal = (opcode == OP_UNCONDITIONAL_JMP);
   assign jimm   = {{12{jimm_bits[31]}}, jimm_bits[19:12], jimm_bits[20],
                    jimm_bits[30:21], 1'b0};

   // Follow the jump statically so decode never has to redirect for it
   always_comb begin
      next_pc = pc + 32'd4;
      take    = 1'b0;
      if (is_jal) begin
         next_pc = pc + jimm;
         take    = 1'b1;
      end
   end
`else
   // Sequential fetch only; 32-bit add wraps naturally
   assign next_pc = pc + 32'd4;
   assign take    = 1'b0;
`endif

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch + IF/ID register; optional static JAL following via IF_STATIC_JAL_EN.
// Latency: 1 clk from accepted fetch to IF_ID_instruction; each memory wait cycle yields one bubble.
// Backpressure: stall holds IF/ID; a word accepted under stall parks in a hold buffer (no request until released).
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h00000000,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] IF_ID_instruction,
   output logic [31:0] IF_ID_pc,
   output logic        IF_ID_valid,
   output logic        IF_ID_take
);

   import if_fetch_stage_pkg::*;

   logic [1:0]  state;
   logic [31:0] pc_q;
   ifid_t       hold_q;
   logic [31:0] fetch_next_pc;
   logic        fetch_take;

   if_next_pc u_next_pc (
      .pc        (pc_q),
`ifdef IF_STATIC_JAL_EN
      .opcode    (imem_rdata[6:0]),
      .jimm_bits (imem_rdata[31:12]),
`endif
      .next_pc   (fetch_next_pc),
      .take      (fetch_take)
   );

   // The request is live only in REQ; the address is the architectural fetch PC
   assign imem_req  = (state == ST_REQ);
   assign imem_addr = pc_q;

   // Fetch FSM, PC, hold buffer and IF/ID register; redirect overrides everything but IDLE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= ST_IDLE;
         pc_q              <= RESET_PC;
         hold_q            <= {NOP_INSTR, 32'h0, 1'b0};
         IF_ID_instruction <= NOP_INSTR;
         IF_ID_pc          <= 32'h0;
         IF_ID_valid       <= 1'b0;
         IF_ID_take        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               state <= ST_REQ;
            end

            ST_REQ: begin
               if (redirect) begin
                  pc_q              <= redirect_pc;
                  IF_ID_instruction <= NOP_INSTR;
                  IF_ID_valid       <= 1'b0;
                  IF_ID_take        <= 1'b0;
               end else if (imem_ready && !stall) begin
                  IF_ID_instruction <= imem_rdata;
                  IF_ID_pc          <= pc_q;
                  IF_ID_valid       <= 1'b1;
                  IF_ID_take        <= fetch_take;
                  pc_q              <= fetch_next_pc;
               end else if (imem_ready) begin
                  // Decode is stalled: park the returned word until it can move on
                  hold_q <= {imem_rdata, pc_q, fetch_take};
                  pc_q   <= fetch_next_pc;
                  state  <= ST_HOLD;
               end else if (!stall) begin
                  IF_ID_instruction <= NOP_INSTR;
                  IF_ID_valid       <= 1'b0;
               end
            end

            ST_HOLD: begin
               if (redirect) begin
                  pc_q              <= redirect_pc;
                  hold_q            <= {NOP_INSTR, 32'h0, 1'b0};
                  IF_ID_instruction <= NOP_INSTR;
                  IF_ID_valid       <= 1'b0;
                  IF_ID_take        <= 1'b0;
                  state             <= ST_REQ;
               end else if (!stall) begin
                  IF_ID_instruction <= hold_q.instr;
                  IF_ID_pc          <= hold_q.pc;
                  IF_ID_valid       <= 1'b1;
                  IF_ID_take        <= hold_q.take;
                  state             <= ST_REQ;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus randomized traffic vs. a queue-based model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_if_fetch_stage;

   localparam logic [31:0] NOP = 32'h00000013;
   localparam logic [31:0] JAL_WORD = 32'h0100006F;
   localparam logic [31:0] JAL_ADDR = 32'h00000020;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [31:0] IF_ID_instruction;
   logic [31:0] IF_ID_pc;
   logic        IF_ID_valid;
   logic        IF_ID_take;

   logic        jal_en = 1'b0;
   int          checks = 0;
   int          errors = 0;

   if_fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
      .clk               (clk),
      .rst               (rst),
      .imem_req          (imem_req),
      .imem_addr         (imem_addr),
      .imem_rdata        (imem_rdata),
      .imem_ready        (imem_ready),
      .stall             (stall),
      .redirect          (redirect),
      .redirect_pc       (redirect_pc),
      .IF_ID_instruction (IF_ID_instruction),
      .IF_ID_pc          (IF_ID_pc),
      .IF_ID_valid       (IF_ID_valid),
      .IF_ID_take        (IF_ID_take)
   );

   always #5 clk = ~clk;

   // Memory contents: address hash with an OP-IMM opcode, so never a JAL by accident
   function automatic logic [31:0] hash_word(input logic [31:0] a);
      logic [31:0] h;
      h = (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
      return {h[31:7], 7'b0010011};
   endfunction

   assign imem_rdata = (jal_en && imem_addr == JAL_ADDR) ? JAL_WORD : hash_word(imem_addr);

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        take;
   } slot_t;

   bit          m_started;
   logic [31:0] m_pc;
   slot_t       m_parked[$];
   logic [31:0] m_instr;
   logic [31:0] m_ifpc;
   bit          m_valid;
   bit          m_take;

   function automatic logic [31:0] model_mem(input logic [31:0] a);
      return (jal_en && a == JAL_ADDR) ? JAL_WORD : hash_word(a);
   endfunction

   task automatic model_next(input logic [31:0] pc, input logic [31:0] w,
                             output logic [31:0] np, output bit tk);
      np = pc + 32'd4;
      tk = 1'b0;
`ifdef IF_STATIC_JAL_EN
      if (w[6:0] == 7'b1101111) begin
         np = pc + {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
         tk = 1'b1;
      end
`else
      if (w == 32'hFFFFFFFF) np = pc + 32'd4;
`endif
   endtask

   function automatic void model_reset();
      m_started = 1'b0;
      m_pc      = 32'h0;
      m_parked.delete();
      m_instr   = NOP;
      m_ifpc    = 32'h0;
      m_valid   = 1'b0;
      m_take    = 1'b0;
   endfunction

   function automatic bit model_req();
      return m_started && (m_parked.size() == 0);
   endfunction

   // Apply one cycle of inputs (called just after a negedge) and advance the model across the posedge
   task automatic drive_cycle(input bit rdy, input bit stl, input bit rdr, input logic [31:0] rpc);
      logic [31:0] w;
      logic [31:0] np;
      bit          tk;
      imem_ready  = rdy;
      stall       = stl;
      redirect    = rdr;
      redirect_pc = rpc;
      if (!m_started) begin
         m_started = 1'b1;
      end else if (rdr) begin
         m_pc    = rpc;
         m_parked.delete();
         m_instr = NOP;
         m_valid = 1'b0;
         m_take  = 1'b0;
      end else if (m_parked.size() != 0) begin
         if (!stl) begin
            m_instr = m_parked[0].instr;
            m_ifpc  = m_parked[0].pc;
            m_take  = m_parked[0].take;
            m_valid = 1'b1;
            m_parked.delete();
         end
      end else if (rdy) begin
         w = model_mem(m_pc);
         model_next(m_pc, w, np, tk);
         if (stl) begin
            m_parked.push_back({w, m_pc, tk});
         end else begin
            m_instr = w;
            m_ifpc  = m_pc;
            m_valid = 1'b1;
            m_take  = tk;
         end
         m_pc = np;
      end else if (!stl) begin
         m_instr = NOP;
         m_valid = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      imem_ready = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 00000000", imem_addr); end
      checks++; if (IF_ID_instruction !== NOP) begin errors++; $display("FAIL reset_instr got %h want %h", IF_ID_instruction, NOP); end
      checks++; if (IF_ID_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 00000000", IF_ID_pc); end
      checks++; if (IF_ID_valid !== 1'b0 || IF_ID_take !== 1'b0) begin errors++; $display("FAIL reset_valid_take got %0b/%0b want 0/0", IF_ID_valid, IF_ID_take); end
      rst = 1'b0;
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      checks++; if (imem_req !== 1'b1 || IF_ID_valid !== 1'b0) begin errors++; $display("FAIL idle_exit req/valid got %0b/%0b want 1/0", imem_req, IF_ID_valid); end
   endtask

   task automatic test_zero_wait();
      logic [31:0] exp_pc;
      do_reset();
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
         exp_pc = 32'(i * 4);
         checks++; if (IF_ID_pc !== exp_pc || IF_ID_valid !== 1'b1) begin errors++; $display("FAIL zero_wait[%0d] pc/valid got %h/%0b want %h/1", i, IF_ID_pc, IF_ID_valid, exp_pc); end
         checks++; if (IF_ID_instruction !== hash_word(exp_pc)) begin errors++; $display("FAIL zero_wait_instr[%0d] got %h want %h", i, IF_ID_instruction, hash_word(exp_pc)); end
      end
   endtask

   task automatic test_wait_states();
      do_reset();
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 2; i++) begin
         drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
         checks++; if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin errors++; $display("FAIL wait_addr[%0d] got %h/%0b want 00000008/1", i, imem_addr, imem_req); end
         checks++; if (IF_ID_valid !== 1'b0 || IF_ID_instruction !== NOP) begin errors++; $display("FAIL wait_bubble[%0d] got %0b/%h want 0/%h", i, IF_ID_valid, IF_ID_instruction, NOP); end
      end
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      checks++; if (IF_ID_pc !== 32'h8 || IF_ID_valid !== 1'b1) begin errors++; $display("FAIL wait_resume got %h/%0b want 00000008/1", IF_ID_pc, IF_ID_valid); end
   endtask

   task automatic test_stall_accept();
      do_reset();
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
         checks++; if (IF_ID_pc !== 32'h0 || IF_ID_valid !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d] got %h/%0b want 00000000/1", i, IF_ID_pc, IF_ID_valid); end
         checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d] got %0b want 0", i, imem_req); end
      end
      drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      checks++; if (IF_ID_pc !== 32'h4 || IF_ID_instruction !== hash_word(32'h4)) begin errors++; $display("FAIL stall_release got %h/%h want 00000004/%h", IF_ID_pc, IF_ID_instruction, hash_word(32'h4)); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL stall_resume_addr got %0b/%h want 1/00000008", imem_req, imem_addr); end
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      checks++; if (IF_ID_pc !== 32'h8 || IF_ID_valid !== 1'b1) begin errors++; $display("FAIL stall_next got %h/%0b want 00000008/1", IF_ID_pc, IF_ID_valid); end
   endtask

   task automatic test_redirect_stall();
      do_reset();
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      drive_cycle(1'b1, 1'b1, 1'b1, 32'h100);
      checks++; if (IF_ID_valid !== 1'b0 || IF_ID_instruction !== NOP || IF_ID_take !== 1'b0) begin errors++; $display("FAIL redir_flush got %0b/%h/%0b want 0/%h/0", IF_ID_valid, IF_ID_instruction, IF_ID_take, NOP); end
      checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL redir_addr got %h want 00000100", imem_addr); end
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      checks++; if (IF_ID_pc !== 32'h100 || IF_ID_valid !== 1'b1) begin errors++; $display("FAIL redir_load got %h/%0b want 00000100/1", IF_ID_pc, IF_ID_valid); end
   endtask

   task automatic test_wrap();
      do_reset();
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      drive_cycle(1'b0, 1'b0, 1'b1, 32'hFFFFFFFC);
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      checks++; if (IF_ID_pc !== 32'hFFFFFFFC || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap got pc %h addr %h want fffffffc/00000000", IF_ID_pc, imem_addr); end
   endtask

   task automatic test_static_jal();
      logic [31:0] exp_addr;
      bit          exp_take;
`ifdef IF_STATIC_JAL_EN
      exp_addr = 32'h30; exp_take = 1'b1;
`else
      exp_addr = 32'h24; exp_take = 1'b0;
`endif
      jal_en = 1'b1;
      do_reset();
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      drive_cycle(1'b0, 1'b0, 1'b1, JAL_ADDR);
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      checks++; if (IF_ID_instruction !== JAL_WORD || IF_ID_pc !== JAL_ADDR) begin errors++; $display("FAIL jal_load got %h@%h want %h@%h", IF_ID_instruction, IF_ID_pc, JAL_WORD, JAL_ADDR); end
      checks++; if (imem_addr !== exp_addr || IF_ID_take !== exp_take) begin errors++; $display("FAIL jal_target got %h/%0b want %h/%0b", imem_addr, IF_ID_take, exp_addr, exp_take); end
      jal_en = 1'b0;
   endtask

   task automatic test_async_reset();
      do_reset();
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      #2 rst = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL async_rst_req got %0b/%h want 0/00000000", imem_req, imem_addr); end
      checks++; if (IF_ID_valid !== 1'b0 || IF_ID_instruction !== NOP || IF_ID_pc !== 32'h0) begin errors++; $display("FAIL async_rst_ifid got %0b/%h/%h want 0/%h/00000000", IF_ID_valid, IF_ID_instruction, IF_ID_pc, NOP); end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_random();
      bit          rdy, stl, rdr;
      logic [31:0] r, rpc;
      jal_en = 1'b1;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         rdy = ($urandom_range(0, 9) < 7);
         stl = ($urandom_range(0, 3) == 0);
         rdr = ($urandom_range(0, 19) == 0);
         r   = $urandom();
         case ($urandom_range(0, 3))
            0:       rpc = JAL_ADDR;
            1:       rpc = 32'hFFFFFFF8;
            default: rpc = {r[31:2], 2'b00};
         endcase
         drive_cycle(rdy, stl, rdr, rpc);
         checks++; if (imem_req !== model_req() || imem_addr !== m_pc) begin errors++; $display("FAIL rnd_fetch[%0d] got %0b/%h want %0b/%h", i, imem_req, imem_addr, model_req(), m_pc); end
         checks++; if (IF_ID_valid !== m_valid || IF_ID_instruction !== m_instr || IF_ID_take !== m_take) begin errors++; $display("FAIL rnd_ifid[%0d] got %0b/%h/%0b want %0b/%h/%0b", i, IF_ID_valid, IF_ID_instruction, IF_ID_take, m_valid, m_instr, m_take); end
         if (m_valid) begin
            checks++; if (IF_ID_pc !== m_ifpc) begin errors++; $display("FAIL rnd_pc[%0d] got %h want %h", i, IF_ID_pc, m_ifpc); end
         end
      end
      jal_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_stall_accept();
      test_redirect_stall();
      test_wrap();
      test_static_jal();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
